// File: rtl/axi_irq_controller_if.sv
// AXI4-Lite style register bus for axi_irq_controller: AW/W/B write and AR/R read channels.
// The master modport drives requests; the slave modport is the controller side.
interface axi_irq_controller_if;
  logic        AxiWriteAddrValid_ValIn;
  logic        AxiWriteAddrReady_RdyOut;
  logic [27:0] AxiWriteAddrAddress_AdrIn;
  logic        AxiWriteDataValid_ValIn;
  logic        AxiWriteDataReady_RdyOut;
  logic [31:0] AxiWriteDataData_DatIn;
  logic [3:0]  AxiWriteDataStrobe_DatIn;
  logic        AxiWriteRespValid_ValOut;
  logic        AxiWriteRespReady_RdyIn;
  logic [1:0]  AxiWriteRespResponse_DatOut;
  logic        AxiReadAddrValid_ValIn;
  logic        AxiReadAddrReady_RdyOut;
  logic [27:0] AxiReadAddrAddress_AdrIn;
  logic        AxiReadDataValid_ValOut;
  logic        AxiReadDataReady_RdyIn;
  logic [31:0] AxiReadDataData_DatOut;
  logic [1:0]  AxiReadDataResponse_DatOut;

  modport master (
    output AxiWriteAddrValid_ValIn, AxiWriteAddrAddress_AdrIn,
    output AxiWriteDataValid_ValIn, AxiWriteDataData_DatIn, AxiWriteDataStrobe_DatIn,
    output AxiWriteRespReady_RdyIn, AxiReadAddrValid_ValIn, AxiReadAddrAddress_AdrIn,
    output AxiReadDataReady_RdyIn,
    input  AxiWriteAddrReady_RdyOut, AxiWriteDataReady_RdyOut,
    input  AxiWriteRespValid_ValOut, AxiWriteRespResponse_DatOut,
    input  AxiReadAddrReady_RdyOut, AxiReadDataValid_ValOut,
    input  AxiReadDataData_DatOut, AxiReadDataResponse_DatOut
  );

  modport slave (
    input  AxiWriteAddrValid_ValIn, AxiWriteAddrAddress_AdrIn,
    input  AxiWriteDataValid_ValIn, AxiWriteDataData_DatIn, AxiWriteDataStrobe_DatIn,
    input  AxiWriteRespReady_RdyIn, AxiReadAddrValid_ValIn, AxiReadAddrAddress_AdrIn,
    input  AxiReadDataReady_RdyIn,
    output AxiWriteAddrReady_RdyOut, AxiWriteDataReady_RdyOut,
    output AxiWriteRespValid_ValOut, AxiWriteRespResponse_DatOut,
    output AxiReadAddrReady_RdyOut, AxiReadDataValid_ValOut,
    output AxiReadDataData_DatOut, AxiReadDataResponse_DatOut
  );
endinterface

// File: rtl/axi_irq_controller.sv
// Two-source interrupt controller with an AXI-Lite register file (CONTROL/STATUS/MASK/SET/VERSION).
// Define AXI_IRQ_CONTROLLER_SOFTTRIG_EN to make the SET register (0x0C) raise STATUS bits from software.
module axi_irq_controller #(
  parameter logic [31:0] AxiAddressRangeLow_Gen  = 32'h0000_0000,
  parameter logic [31:0] AxiAddressRangeHigh_Gen = 32'h0000_00FF
) (
  input  logic                       SysClk_ClkIn,
  input  logic                       SysRst_RstIn,
  axi_irq_controller_if.slave        axi,
  input  logic [1:0]                 Event_EvtIn,
  output logic [1:0]                 Irq_DatOut
);
  localparam logic [31:0] SPAN        = AxiAddressRangeHigh_Gen - AxiAddressRangeLow_Gen;
  localparam logic [31:0] OFS_CONTROL = 32'h00;
  localparam logic [31:0] OFS_STATUS  = 32'h04;
  localparam logic [31:0] OFS_MASK    = 32'h08;
  localparam logic [31:0] OFS_SET     = 32'h0C;
  localparam logic [31:0] OFS_VERSION = 32'h10;
  localparam logic [31:0] VERSION     = 32'h0001_0000;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic { WrIdle, WrResp } wr_state_e;
  typedef enum logic { RdIdle, RdResp } rd_state_e;

  wr_state_e   wr_state_q;
  rd_state_e   rd_state_q;
  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic        ctrl_q, ctrl_d;
  logic [1:0]  status_q, status_d, mask_q, mask_d;
  logic [1:0]  evt_prev_q, evt_edge_q, irq_q;
  logic [1:0]  clr, sw_set;
  logic [31:0] rd_data_c;

  // Borrow bit of the 33-bit subtraction flags addresses below the window.
  logic [32:0] wr_rel, rd_rel;
  logic        wr_hit, rd_hit, wr_fire, rd_fire;
  assign wr_rel  = {5'b0, axi.AxiWriteAddrAddress_AdrIn} - {1'b0, AxiAddressRangeLow_Gen};
  assign rd_rel  = {5'b0, axi.AxiReadAddrAddress_AdrIn}  - {1'b0, AxiAddressRangeLow_Gen};
  assign wr_hit  = !wr_rel[32] && (wr_rel[31:0] <= SPAN);
  assign rd_hit  = !rd_rel[32] && (rd_rel[31:0] <= SPAN);
  assign wr_fire = awready_q && axi.AxiWriteAddrValid_ValIn && axi.AxiWriteDataValid_ValIn;
  assign rd_fire = arready_q && axi.AxiReadAddrValid_ValIn;

  logic unused_wdata;
  assign unused_wdata = ^{axi.AxiWriteDataData_DatIn[31:2], axi.AxiWriteDataStrobe_DatIn[3:1]};

  // Every writable bit lives in byte 0, so strobe bit 0 gates all register effects.
  always_comb begin
    ctrl_d = ctrl_q;
    mask_d = mask_q;
    clr    = '0;
    sw_set = '0;
    if (wr_fire && wr_hit && axi.AxiWriteDataStrobe_DatIn[0]) begin
      case (wr_rel[31:0])
        OFS_CONTROL: ctrl_d = axi.AxiWriteDataData_DatIn[0];
        OFS_STATUS:  clr    = axi.AxiWriteDataData_DatIn[1:0];
        OFS_MASK:    mask_d = axi.AxiWriteDataData_DatIn[1:0];
`ifdef AXI_IRQ_CONTROLLER_SOFTTRIG_EN
        OFS_SET:     sw_set = axi.AxiWriteDataData_DatIn[1:0];
`endif
        default: ;
      endcase
    end
    // Sets are OR-ed in after the clear so a coincident set wins.
    status_d = (status_q & ~clr) | evt_edge_q | sw_set;
  end

  always_comb begin
    rd_data_c = '0;
    case (rd_rel[31:0])
      OFS_CONTROL: rd_data_c = {31'b0, ctrl_q};
      OFS_STATUS:  rd_data_c = {30'b0, status_q};
      OFS_MASK:    rd_data_c = {30'b0, mask_q};
      OFS_VERSION: rd_data_c = VERSION;
      default: ;
    endcase
  end

  always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
    if (SysRst_RstIn) begin
      ctrl_q     <= 1'b0;
      status_q   <= '0;
      mask_q     <= '0;
      evt_prev_q <= '0;
      evt_edge_q <= '0;
      irq_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      status_q   <= status_d;
      mask_q     <= mask_d;
      evt_prev_q <= Event_EvtIn;
      evt_edge_q <= Event_EvtIn & ~evt_prev_q;
      irq_q      <= {2{ctrl_q}} & status_q & mask_q;
    end
  end

  // Ready is raised only once both AW and W are presented, so neither is accepted alone.
  always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
    if (SysRst_RstIn) begin
      wr_state_q <= WrIdle;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      case (wr_state_q)
        WrIdle: begin
          if (wr_fire) begin
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= wr_hit ? RESP_OKAY : RESP_DECERR;
            wr_state_q <= WrResp;
          end else begin
            awready_q  <= axi.AxiWriteAddrValid_ValIn && axi.AxiWriteDataValid_ValIn && !bvalid_q;
          end
        end
        WrResp: begin
          if (axi.AxiWriteRespReady_RdyIn) begin
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_state_q <= WrIdle;
          end
        end
        default: wr_state_q <= WrIdle;
      endcase
    end
  end

  always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
    if (SysRst_RstIn) begin
      rd_state_q <= RdIdle;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        RdIdle: begin
          if (rd_fire) begin
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rresp_q    <= rd_hit ? RESP_OKAY : RESP_DECERR;
            rdata_q    <= rd_hit ? rd_data_c : 32'h0;
            rd_state_q <= RdResp;
          end else begin
            arready_q  <= axi.AxiReadAddrValid_ValIn && !rvalid_q;
          end
        end
        RdResp: begin
          if (axi.AxiReadDataReady_RdyIn) begin
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            rd_state_q <= RdIdle;
          end
        end
        default: rd_state_q <= RdIdle;
      endcase
    end
  end

  assign axi.AxiWriteAddrReady_RdyOut    = awready_q;
  assign axi.AxiWriteDataReady_RdyOut    = awready_q;
  assign axi.AxiWriteRespValid_ValOut    = bvalid_q;
  assign axi.AxiWriteRespResponse_DatOut = bresp_q;
  assign axi.AxiReadAddrReady_RdyOut     = arready_q;
  assign axi.AxiReadDataValid_ValOut     = rvalid_q;
  assign axi.AxiReadDataData_DatOut      = rdata_q;
  assign axi.AxiReadDataResponse_DatOut  = rresp_q;
  assign Irq_DatOut                      = irq_q;
endmodule
